counter_sched: RTL
==================

# counter_sched

Round-robin scheduler that shares one enable-pipelined counter (`counter`, width N, two-stage enable latency) among NREQ requesters. Each requester asks for a burst of increments. The block grants one requester at a time, drives the counter enable for the requested number of cycles, and waits for the counter's enable pipeline to drain. It then returns the settled count to the winner with a one-cycle `done` pulse. The block sits directly in front of the counter's `en` input and reads back its `cnt` output.

## Interface
- N, 7: counter width; matches the counter instance.
- NREQ, 4: number of requesters (2..8).
- LW, 4: burst-length field width.
- LAT, 2: enable-to-count latency of the counter, in cycles.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high; the same net drives the counter's rst.
- req  in  NREQ  per-requester request level; held until the matching `done`.
- len  in  NREQ*LW  per-requester burst length; slice i = len[i*LW +: LW]; sampled at grant.
- cnt_in  in  N  counter output `cnt`.
- en_out  out  1  counter enable.
- gnt  out  NREQ  one-hot grant; held from grant through the DONE cycle.
- done  out  NREQ  one-hot, one-cycle completion pulse.
- result  out  N  cnt_in captured in the DONE cycle; held until the next DONE.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. All outputs are registered.
- IDLE
  - If any req bit is set, select the winner by round-robin: the first set bit at or after `ptr`, wrapping modulo NREQ.
  - Latch len[winner] into `rem`. Set gnt[winner].
  - Go to ISSUE, or directly to DRAIN if the latched length is 0.
- ISSUE
  - en_out=1 each cycle; `rem` decrements each cycle.
  - On the cycle where `rem`==1, go to DRAIN. en_out is high for exactly `len` cycles.
- DRAIN
  - en_out=0 for LAT+1 cycles, counted by a drain counter, so the counter's last increment is visible on cnt_in.
  - Then go to DONE.
- DONE
  - done[winner]=1 for one cycle; result <= cnt_in.
  - ptr <= (winner+1) mod NREQ.
  - gnt clears at the next edge; go to IDLE.
- Requests
  - Only the granted requester is serviced. Other req bits are ignored until IDLE.
  - A drop of req[winner] mid-burst is ignored; the burst runs to completion.
  - If req[winner] is still high in the cycle after DONE, it is a new request and competes normally. ptr has already advanced, so the other requesters get priority.
  - len changes after grant have no effect.
- Arithmetic
  - Counter wraps modulo 2^N. result is raw cnt_in with no saturation.
  - `rem` is LW bits; maximum burst is 2^LW-1 increments.
- Reset
  - At the first edge with rst=1: state=IDLE, ptr=0, gnt=0, done=0, en_out=0, result=0, busy=0, rem=0, drain counter=0.
  - A reset mid-burst aborts the burst; no done is issued.
  - The counter is cleared by the same reset, so there is no partial-count leakage.

## Timing
- Request seen in IDLE at edge t: gnt/busy high after t. en_out high for cycles t+1..t+len.
- DRAIN covers cycles t+len+1..t+len+LAT+1. done and result valid at cycle t+len+LAT+2.
- IDLE is re-entered at t+len+LAT+3.
- Latency from req sampling to done is len+LAT+2 cycles. For len=0 it is LAT+2 cycles.
- Minimum spacing between consecutive grants is len+LAT+3 cycles (one IDLE cycle between bursts).
- gnt, en_out and done never change except on a clock edge; no combinational paths from inputs to outputs.

## Test plan
- Reset; req=0001, len0=3 at cycle 1 -> en_out high 3 cycles, done[0] at cycle len+LAT+2=7 after sampling, result=3, busy low afterward.
- req=1111 held, every len=1, from reset -> grant order 0,1,2,3,0; each done shows result incrementing by 1 (1,2,3,4,5).
- req=0010 with len1=0 -> no en_out pulse, done[1] after LAT+2=4 cycles, result unchanged from the previous value.
- Counter at 127 (N=7), burst len=2 -> result=1 (wrap-around).
- rst asserted in the second ISSUE cycle of a len=5 burst -> en_out=0, gnt=0, busy=0 at the next edge; no done; counter=0; next request restarts with ptr=0.
- req[2] dropped mid-burst while req[0] asserts -> burst of requester 2 completes with done[2]; requester 0 is granted in the following IDLE cycle.

Source files
------------

// File: rtl/counter_sched.sv
// counter_sched: round-robin arbiter in front of a shared, enable-pipelined
// counter. It grants one requester, pulses the counter enable for that
// requester's burst length, waits for the enable pipeline to settle, and then
// hands the settled count back with a one-cycle done pulse.
module counter_sched #(
  parameter int N    = 7,
  parameter int NREQ = 4,
  parameter int LW   = 4,
  parameter int LAT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*LW-1:0] len,
  input  logic [N-1:0]       cnt_in,
  output logic               en_out,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [N-1:0]       result,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  win;
  logic [LW-1:0]  rem;
  logic [DW-1:0]  dcnt;

  logic           pick_vld;
  logic [PW-1:0]  pick;
  logic [LW-1:0]  pick_len;
  int             pidx;

  // Round-robin pick: scan downward so the lowest offset from ptr wins last.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    pidx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pidx = (int'(ptr) + k) % NREQ;
      if (req[pidx]) begin
        pick_vld = 1'b1;
        pick     = PW'(pidx);
      end
    end
    pick_len = len[int'(pick)*LW +: LW];
  end

  // Scheduler FSM; every output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      win    <= '0;
      rem    <= '0;
      dcnt   <= '0;
      en_out <= 1'b0;
      gnt    <= '0;
      done   <= '0;
      result <= '0;
      busy   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            win  <= pick;
            gnt  <= NREQ'(1) << pick;
            busy <= 1'b1;
            rem  <= pick_len;
            dcnt <= '0;
            if (pick_len == '0) begin
              // Zero-length burst: skip the enable phase entirely.
              state <= DRAIN;
            end else begin
              state  <= ISSUE;
              en_out <= 1'b1;
            end
          end
        end
        ISSUE: begin
          rem <= rem - 1'b1;
          if (rem == LW'(1)) begin
            en_out <= 1'b0;
            dcnt   <= '0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          // LAT+1 quiet cycles so the last increment has reached cnt_in.
          if (dcnt == DW'(LAT)) begin
            state  <= DONE;
            done   <= gnt;
            result <= cnt_in;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
